// File: rtl/mmc_crc_pkg.sv
// Shared types and helpers for the MMC/SD per-lane CRC engine.
// Holds the FSM state enum, CRC16-CCITT constants and the LFSR step.
package mmc_crc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        SHIFT,
        CHECK
    } state_t;

    // Widest CRC register the step function handles.
    localparam int MAX_W = 32;

    localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
    localparam logic [15:0] CRC16_CCITT_INIT = 16'h0000;

    // One serial LFSR step; msb is the current top bit of the register.
    // Bit 0 always receives the feedback, whether or not poly has it set.
    function automatic logic [MAX_W-1:0] lfsr_next(
        input logic [MAX_W-1:0] r,
        input logic             msb,
        input logic             d,
        input logic [MAX_W-1:0] poly
    );
        logic fb;
        fb = d ^ msb;
        return {r[MAX_W-2:0], 1'b0} ^ (fb ? (poly | MAX_W'(1)) : '0);
    endfunction

endpackage

// File: rtl/mmc_crc16_lanes_if.sv
// Data-path bundle between the MMC data shifter and the CRC engine.
// The controller side uses master; the CRC engine uses slave.
interface mmc_crc16_lanes_if #(
    parameter int LANES = 4,
    parameter int CRC_W = 16
);

    logic                   start;
    logic                   mode;
    logic [LANES-1:0]       din;
    logic                   dvld;
    logic                   last;
    logic                   shift_en;
    logic [LANES-1:0]       crc_out;
    logic                   crc_vld;
    logic                   busy;
    logic                   done;
    logic [LANES-1:0]       crc_err;
    logic [LANES*CRC_W-1:0] crc_dout;

    modport master (
        output start, mode, din, dvld, last, shift_en,
        input  crc_out, crc_vld, busy, done, crc_err, crc_dout
    );

    modport slave (
        input  start, mode, din, dvld, last, shift_en,
        output crc_out, crc_vld, busy, done, crc_err, crc_dout
    );

endinterface

// File: rtl/mmc_crc_lane.sv
// One CRC register for a single DAT line.
// load restarts it, step absorbs din, shift moves it out MSB-first.
module mmc_crc_lane
    import mmc_crc_pkg::*;
#(
    parameter int               CRC_W = 16,
    parameter logic [CRC_W-1:0] POLY  = CRC_W'(CRC16_CCITT_POLY),
    parameter logic [CRC_W-1:0] INIT  = CRC_W'(CRC16_CCITT_INIT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             shift,
    input  logic             din,
    output logic [CRC_W-1:0] r,
    output logic [CRC_W-1:0] nxt
);

    // Register value after absorbing din this cycle.
    always_comb begin
        nxt = CRC_W'(lfsr_next(MAX_W'(r), r[CRC_W-1], din, MAX_W'(POLY)));
    end

    // Restart has priority over update, update over serialisation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r <= INIT;
        end else if (load) begin
            r <= INIT;
        end else if (step) begin
            r <= nxt;
        end else if (shift) begin
            r <= {r[CRC_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mmc_crc16_lanes.sv
// Per-lane CRC generator/checker for the MMC/SD DAT lines.
// One shared FSM and bit counter drive LANES independent LFSRs.
module mmc_crc16_lanes
    import mmc_crc_pkg::*;
#(
    parameter int               LANES = 4,
    parameter int               CRC_W = 16,
    parameter logic [CRC_W-1:0] POLY  = CRC_W'(CRC16_CCITT_POLY),
    parameter logic [CRC_W-1:0] INIT  = CRC_W'(CRC16_CCITT_INIT)
) (
    input  logic             clk,
    input  logic             rst,
    mmc_crc16_lanes_if.slave bus
);

    localparam int               CNT_W    = $clog2(CRC_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CRC_W - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             mode_q;
    logic             vld_q;
    logic             busy_q;
    logic             done_q;
    logic [LANES-1:0] err_q;
    logic             load;
    logic             step;
    logic             shift;
    logic [LANES-1:0] msb;
    logic [LANES-1:0] res_nz;

    // Lane controls; start overrides any data or shift request.
    always_comb begin
        load  = bus.start;
        step  = !bus.start && bus.dvld &&
                (state == ACCUM || state == CHECK);
        shift = !bus.start && bus.shift_en && (state == SHIFT);
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [CRC_W-1:0] r;
        logic [CRC_W-1:0] nxt;

        mmc_crc_lane #(
            .CRC_W (CRC_W),
            .POLY  (POLY),
            .INIT  (INIT)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .load  (load),
            .step  (step),
            .shift (shift),
            .din   (bus.din[i]),
            .r     (r),
            .nxt   (nxt)
        );

        assign bus.crc_dout[i*CRC_W +: CRC_W] = r;
        assign msb[i]    = r[CRC_W-1];
        assign res_nz[i] = |nxt;
    end

    assign bus.crc_out = vld_q ? msb : '0;
    assign bus.crc_vld = vld_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.crc_err = err_q;

    // Block sequencing, bit counting and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            mode_q <= 1'b0;
            vld_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (bus.start) begin
                state  <= ACCUM;
                cnt    <= '0;
                mode_q <= bus.mode;
                err_q  <= '0;
                busy_q <= 1'b1;
                vld_q  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: ;
                    ACCUM: begin
                        if (bus.dvld && bus.last) begin
                            state <= mode_q ? CHECK : SHIFT;
                            cnt   <= '0;
                            vld_q <= !mode_q;
                        end
                    end
                    SHIFT: begin
                        if (bus.shift_en) begin
                            if (cnt == CNT_LAST) begin
                                state  <= IDLE;
                                cnt    <= '0;
                                vld_q  <= 1'b0;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                    end
                    CHECK: begin
                        if (bus.dvld) begin
                            if (cnt == CNT_LAST) begin
                                state  <= IDLE;
                                cnt    <= '0;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                                err_q  <= res_nz;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mmc_crc16_lanes.sv
// Self-checking bench for mmc_crc16_lanes (8 lanes, CRC16-CCITT, INIT 0).
// Reference CRCs come from polynomial long division of the augmented message.
module tb_mmc_crc16_lanes;
    import mmc_crc_pkg::*;

    localparam int LANES = 8;
    localparam int CRC_W = 16;
    localparam int DW    = LANES * CRC_W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mmc_crc16_lanes_if #(.LANES(LANES), .CRC_W(CRC_W)) bus ();

    mmc_crc16_lanes #(
        .LANES (LANES),
        .CRC_W (CRC_W),
        .POLY  (16'h1021),
        .INIT  (16'h0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0]  fill;
        int          n;
        logic [15:0] exp;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    vec_t        tbl [4];
    bit          lq [LANES][$];
    logic [15:0] ev [LANES];
    logic [DW-1:0] snap;
    logic [LANES-1:0] osnap;
    logic [LANES-1:0] d;
    logic [LANES-1:0] errm;
    logic [LANES-1:0] want;
    logic        m;
    int          len;
    int          bpos;
    string       msg;

    task automatic check(input string name, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.start    = 1'b0;
        bus.mode     = 1'b0;
        bus.din      = '0;
        bus.dvld     = 1'b0;
        bus.last     = 1'b0;
        bus.shift_en = 1'b0;
    endtask

    task automatic do_start(input logic md);
        bus.start = 1'b1;
        bus.mode  = md;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send(input logic [LANES-1:0] v, input logic l);
        bus.dvld = 1'b1;
        bus.din  = v;
        bus.last = l;
        tick();
        bus.dvld = 1'b0;
        bus.last = 1'b0;
        bus.din  = '0;
    endtask

    task automatic feed_lane0(input logic [7:0] b, input logic lastb);
        for (int k = 7; k >= 0; k--)
            send({{(LANES-1){1'b0}}, b[k]}, lastb && k == 0);
    endtask

    // Remainder of M(x)*x^16 divided by x^16+x^12+x^5+1.
    function automatic logic [15:0] ref_rem(input bit q[$]);
        logic [16:0] acc;
        acc = '0;
        for (int i = 0; i < q.size() + 16; i++) begin
            acc = {acc[15:0], (i < q.size()) ? q[i] : 1'b0};
            if (acc[16]) acc = acc ^ 17'h11021;
        end
        return acc[15:0];
    endfunction

    function automatic logic [DW-1:0] pack(input logic [15:0] e [LANES]);
        logic [DW-1:0] p;
        for (int i = 0; i < LANES; i++) p[i*16 +: 16] = e[i];
        return p;
    endfunction

    task automatic clear_ev();
        for (int i = 0; i < LANES; i++) ev[i] = '0;
    endtask

    task automatic shift_out(input string tag);
        logic [LANES-1:0] w;
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < LANES; i++) w[i] = ev[i][15-k];
            check({tag, " crc_out"}, DW'(bus.crc_out), DW'(w));
            check({tag, " crc_vld"}, DW'(bus.crc_vld), 1);
            check({tag, " early done"}, DW'(bus.done), 0);
            bus.shift_en = 1'b1;
            tick();
            bus.shift_en = 1'b0;
        end
        check({tag, " done"}, DW'(bus.done), 1);
        check({tag, " busy end"}, DW'(bus.busy), 0);
        check({tag, " vld end"}, DW'(bus.crc_vld), 0);
        tick();
        check({tag, " done drop"}, DW'(bus.done), 0);
    endtask

    // 4-bit bus CHK of "123456789" split nibble-wise across DAT3..0.
    task automatic chk4(input bit flip, input logic [LANES-1:0] want_err);
        string       s;
        logic [7:0]  c;
        logic [LANES-1:0] v;
        int          cyc;
        s   = "123456789";
        cyc = 0;
        for (int i = 0; i < LANES; i++) lq[i].delete();
        do_start(1'b1);
        for (int j = 0; j < 9; j++) begin
            c = s[j];
            for (int h = 1; h >= 0; h--) begin
                v = {4'b0, (h == 1) ? c[7:4] : c[3:0]};
                for (int i = 0; i < LANES; i++) lq[i].push_back(v[i]);
                if (flip && cyc == 5) v[2] = ~v[2];
                send(v, cyc == 17);
                cyc++;
            end
        end
        for (int i = 0; i < LANES; i++) ev[i] = ref_rem(lq[i]);
        if (!flip) check("chk4 payload regs", bus.crc_dout, pack(ev));
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < LANES; i++) v[i] = ev[i][15-k];
            if (k == 15) begin
                check("chk4 busy pre", DW'(bus.busy), 1);
                check("chk4 done pre", DW'(bus.done), 0);
            end
            send(v, 1'b0);
        end
        check("chk4 done", DW'(bus.done), 1);
        check("chk4 crc_err", DW'(bus.crc_err), DW'(want_err));
        check("chk4 busy end", DW'(bus.busy), 0);
        tick();
        check("chk4 done drop", DW'(bus.done), 0);
        check("chk4 err held", DW'(bus.crc_err), DW'(want_err));
    endtask

    initial begin
        idle_in();
        tbl[0] = '{8'h01, 1,   16'h1021};
        tbl[1] = '{8'h80, 1,   16'h9188};
        tbl[2] = '{8'h00, 4,   16'h0000};
        tbl[3] = '{8'hFF, 512, 16'h7FA1};

        repeat (2) @(posedge clk);
        #1;
        check("rst crc_dout", bus.crc_dout, '0);
        check("rst busy", DW'(bus.busy), 0);
        check("rst done", DW'(bus.done), 0);
        check("rst vld", DW'(bus.crc_vld), 0);
        check("rst err", DW'(bus.crc_err), 0);
        check("rst crc_out", DW'(bus.crc_out), 0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // GEN of the check string on lane 0.
        msg = "123456789";
        do_start(1'b0);
        check("t1 busy", DW'(bus.busy), 1);
        for (int j = 0; j < 9; j++) feed_lane0(msg[j], j == 8);
        check("t1 crc", bus.crc_dout, DW'(16'h31C3));
        clear_ev();
        ev[0] = 16'h31C3;
        shift_out("t1");

        // Fixed-pattern GEN vectors.
        for (int t = 0; t < 4; t++) begin
            do_start(1'b0);
            for (int j = 0; j < tbl[t].n; j++)
                feed_lane0(tbl[t].fill, j == tbl[t].n - 1);
            check("tbl crc", bus.crc_dout, DW'(tbl[t].exp));
            clear_ev();
            ev[0] = tbl[t].exp;
            shift_out("tbl");
        end

        // 4-lane CHK, clean then with one bit flipped on lane 2.
        chk4(1'b0, 8'h00);
        chk4(1'b1, 8'h04);

        // Restart mid-SHIFT at bit 7, then gating checks on a fresh block.
        do_start(1'b0);
        for (int j = 0; j < 9; j++) feed_lane0(msg[j], j == 8);
        for (int k = 0; k < 7; k++) begin
            bus.shift_en = 1'b1;
            tick();
            bus.shift_en = 1'b0;
        end
        bus.start    = 1'b1;
        bus.shift_en = 1'b1;
        bus.dvld     = 1'b1;
        bus.din      = '1;
        tick();
        idle_in();
        check("t4 regs init", bus.crc_dout, '0);
        check("t4 busy", DW'(bus.busy), 1);
        check("t4 vld", DW'(bus.crc_vld), 0);
        check("t4 no done", DW'(bus.done), 0);
        tick();
        check("t4 no done 2", DW'(bus.done), 0);
        send(8'h01, 1'b0);
        snap = bus.crc_dout;
        bus.shift_en = 1'b1;
        tick();
        bus.shift_en = 1'b0;
        check("t6 shift_en in ACCUM", bus.crc_dout, snap);
        for (int k = 6; k >= 0; k--) send({7'b0, k == 7}, k == 0);
        check("t4 crc 80", bus.crc_dout, DW'(16'h9188));
        snap  = bus.crc_dout;
        osnap = bus.crc_out;
        send('1, 1'b1);
        check("t6 dvld in SHIFT regs", bus.crc_dout, snap);
        check("t6 dvld in SHIFT out", DW'(bus.crc_out), DW'(osnap));
        clear_ev();
        ev[0] = 16'h9188;
        shift_out("t4");
        send('1, 1'b1);
        check("t6 dvld in IDLE", bus.crc_dout, '0);
        check("t6 idle busy", DW'(bus.busy), 0);

        // Asynchronous reset in the middle of ACCUM.
        do_start(1'b0);
        send('1, 1'b0);
        send(8'h5A, 1'b0);
        #3;
        rst = 1'b0;
        #1;
        check("t5 regs", bus.crc_dout, '0);
        check("t5 busy", DW'(bus.busy), 0);
        check("t5 done", DW'(bus.done), 0);
        check("t5 vld", DW'(bus.crc_vld), 0);
        check("t5 err", DW'(bus.crc_err), 0);
        check("t5 out", DW'(bus.crc_out), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus.dvld     = 1'b1;
        bus.last     = 1'b1;
        bus.shift_en = 1'b1;
        bus.din      = '1;
        tick();
        tick();
        idle_in();
        check("t5 idle regs", bus.crc_dout, '0);
        check("t5 idle busy", DW'(bus.busy), 0);

        // Random 8-lane blocks against the long-division model.
        for (int b = 0; b < 12; b++) begin
            m   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 24);
            for (int i = 0; i < LANES; i++) lq[i].delete();
            do_start(m);
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus.din      = LANES'($urandom);
                    bus.shift_en = 1'($urandom_range(0, 1));
                    bus.last     = 1'b1;
                    tick();
                    idle_in();
                end
                d = LANES'($urandom);
                for (int i = 0; i < LANES; i++) lq[i].push_back(d[i]);
                send(d, c == len - 1);
            end
            for (int i = 0; i < LANES; i++) ev[i] = ref_rem(lq[i]);
            check("rnd payload regs", bus.crc_dout, pack(ev));
            if (!m) begin
                shift_out("rnd gen");
            end else begin
                errm = LANES'($urandom);
                bpos = $urandom_range(0, 15);
                for (int k = 0; k < 16; k++) begin
                    for (int i = 0; i < LANES; i++) begin
                        d[i] = ev[i][15-k] ^ (errm[i] && k == bpos);
                        lq[i].push_back(d[i]);
                    end
                    send(d, 1'($urandom_range(0, 1)));
                end
                for (int i = 0; i < LANES; i++) want[i] = (ref_rem(lq[i]) != 0);
                check("rnd chk done", DW'(bus.done), 1);
                check("rnd chk err", DW'(bus.crc_err), DW'(want));
                tick();
                check("rnd chk done drop", DW'(bus.done), 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
